// File: rtl/operand_lut.sv
// operand_lut: operand pointer decoder backed by a writable constant table.
// A pointer with its MSB set selects a table constant; otherwise the pointer
// itself is returned zero-extended as a register number. After reset or a
// reload, the table refills with its defaults one entry per cycle, and the
// block reports busy for that whole time.
//
// Handshake: a lookup is taken on a rising edge where rd_req=1 and busy=0.
// rd_valid is high for exactly the next cycle. While rd_valid=0, constant and
// const_flag keep their last values. There is no backpressure. A write is
// taken on a rising edge in READY with wr_en=1 and no reload. A write offered
// while busy is dropped and flagged by a one-cycle wr_err pulse.
module operand_lut #(
   parameter int DW = 8,
   parameter int PW = 5
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          reload,
   input  logic          rd_req,
   input  logic [PW-1:0] rd_ptr,
   input  logic          wr_en,
   input  logic [PW-2:0] wr_idx,
   input  logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          rd_valid,
   output logic [DW-1:0] constant,
   output logic          const_flag,
   output logic          wr_err,
   output logic          dbg_state_o
);

   localparam int DEPTH = 2 ** (PW - 1);
   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;
   localparam logic [PW-2:0] LAST_IDX = '1;

   logic [0:0]    state_q, state_d;
   logic [PW-2:0] cnt_q, cnt_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          rd_valid_q, rd_valid_d;
   logic [DW-1:0] constant_q, constant_d;
   logic          const_flag_q, const_flag_d;
   logic          wr_err_q, wr_err_d;
   logic          wr_go;
   logic          accept;
   logic [PW-2:0] rd_idx;

   // Default contents: a fixed list for the first 16 entries, identity after.
   function automatic logic [DW-1:0] default_entry(input logic [PW-2:0] k);
      logic [31:0] v;
      int          idx;
      idx = int'(k);
      case (idx)
         0:  v = 32'd127;
         1:  v = 32'd1;
         2:  v = 32'd2;
         3:  v = 32'd128;
         4:  v = 32'd8;
         5:  v = 32'd3;
         6:  v = 32'd4;
         7:  v = 32'd5;
         8:  v = 32'd32;
         9:  v = 32'd6;
         10: v = 32'd15;
         11: v = 32'd64;
         12: v = 32'd7;
         13: v = 32'd255;
         14: v = 32'd19;
         15: v = 32'd20;
         default: v = idx;
      endcase
      return v[DW-1:0];
   endfunction

   assign busy        = (state_q == ST_INIT);
   assign dbg_state_o = state_q;
   assign rd_valid    = rd_valid_q;
   assign constant    = constant_q;
   assign const_flag  = const_flag_q;
   assign wr_err      = wr_err_q;

   // A reload cancels a coincident write, so it can never race the refill.
   assign wr_go  = (state_q == ST_READY) && wr_en && !reload;
   assign accept = rd_req && !busy;
   assign rd_idx = rd_ptr[PW-2:0];

   // Next state: step through the refill in INIT, re-enter INIT on reload.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_IDX) begin
            state_d = ST_READY;
         end
      end else if (reload) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end
   end

   // Lookup result and the write-error pulse, computed ahead of the edge.
   always_comb begin
      rd_valid_d   = accept;
      constant_d   = constant_q;
      const_flag_d = const_flag_q;
      wr_err_d     = wr_en && busy && !reload;
      if (accept) begin
         const_flag_d = rd_ptr[PW-1];
         if (rd_ptr[PW-1]) begin
            if (wr_go && (wr_idx == rd_idx)) begin
               constant_d = wr_data;
            end else begin
               constant_d = mem_q[rd_idx];
            end
         end else begin
            constant_d             = '0;
            constant_d[PW-1:0]     = rd_ptr;
         end
      end
   end

   // Control and output registers; Reset overrides every other input.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         rd_valid_q   <= 1'b0;
         constant_q   <= '0;
         const_flag_q <= 1'b0;
         wr_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_valid_q   <= rd_valid_d;
         constant_q   <= constant_d;
         const_flag_q <= const_flag_d;
         wr_err_q     <= wr_err_d;
      end
   end

   // Table storage: refill writes in INIT, user writes in READY.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= default_entry(cnt_q);
         end else if (wr_go) begin
            mem_q[wr_idx] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_operand_lut.sv
// tb_operand_lut: directed checks of operand_lut at default width plus a
// second instance at PW=6, DW=16.
module tb_operand_lut;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       reload = 1'b0;
   logic       rd_req = 1'b0;
   logic [4:0] rd_ptr = '0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_idx = '0;
   logic [7:0] wr_data = '0;
   logic       busy, rd_valid, const_flag, wr_err, dbg_state;
   logic [7:0] constant;

   logic        w_reset = 1'b1;
   logic        w_rd_req = 1'b0;
   logic [5:0]  w_rd_ptr = '0;
   logic        w_busy, w_rd_valid, w_const_flag, w_wr_err, w_dbg_state;
   logic [15:0] w_constant;

   int checks = 0;
   int fails  = 0;

   operand_lut #(.DW(8), .PW(5)) dut (
      .Clk(Clk), .Reset(Reset), .reload(reload), .rd_req(rd_req), .rd_ptr(rd_ptr),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy),
      .rd_valid(rd_valid), .constant(constant), .const_flag(const_flag),
      .wr_err(wr_err), .dbg_state_o(dbg_state)
   );

   operand_lut #(.DW(16), .PW(6)) dut_w (
      .Clk(Clk), .Reset(w_reset), .reload(1'b0), .rd_req(w_rd_req), .rd_ptr(w_rd_ptr),
      .wr_en(1'b0), .wr_idx(5'd0), .wr_data(16'd0), .busy(w_busy),
      .rd_valid(w_rd_valid), .constant(w_constant), .const_flag(w_const_flag),
      .wr_err(w_wr_err), .dbg_state_o(w_dbg_state)
   );

   // Clock and a hard time limit.
   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_ready();
      int g;
      g = 0;
      while (busy && g < 100) begin
         tick();
         g++;
      end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wait_ready: busy=%b required 0", busy); end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) tick();
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
      checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      checks++; if (constant !== 8'd0) begin fails++; $display("FAIL reset_constant: got %0d want 0", constant); end
      checks++; if (const_flag !== 1'b0) begin fails++; $display("FAIL reset_const_flag: got %b want 0", const_flag); end
      checks++; if (wr_err !== 1'b0) begin fails++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
      checks++; if (dbg_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %b want 0", dbg_state); end
   endtask

   task automatic test_init_busy();
      int n;
      rd_req = 1'b1;
      rd_ptr = 5'b10000;
      Reset  = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL init_no_valid: cycle %0d rd_valid=%b want 0", n, rd_valid); end
         n++;
         tick();
      end
      checks++; if (n !== 16) begin fails++; $display("FAIL init_busy_len: got %0d cycles want 16", n); end
      checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL init_first_ready: rd_valid=%b want 0", rd_valid); end
      tick();
      rd_req = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL init_lookup_valid: got %b want 1", rd_valid); end
      checks++; if (constant !== 8'd127) begin fails++; $display("FAIL init_lookup_const: got %0d want 127", constant); end
      checks++; if (const_flag !== 1'b1) begin fails++; $display("FAIL init_lookup_flag: got %b want 1", const_flag); end
      checks++; if (dbg_state !== 1'b1) begin fails++; $display("FAIL init_state_ready: got %b want 1", dbg_state); end
   endtask

   task automatic test_lookup();
      rd_req = 1'b1; rd_ptr = 5'b00110;
      tick();
      rd_req = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL reg_ptr_valid: got %b want 1", rd_valid); end
      checks++; if (constant !== 8'h06) begin fails++; $display("FAIL reg_ptr_const: got %0h want 06", constant); end
      checks++; if (const_flag !== 1'b0) begin fails++; $display("FAIL reg_ptr_flag: got %b want 0", const_flag); end
      rd_req = 1'b1; rd_ptr = 5'b11101;
      tick();
      rd_req = 1'b0; rd_ptr = 5'b00001;
      checks++; if (constant !== 8'd255) begin fails++; $display("FAIL entry13_const: got %0d want 255", constant); end
      checks++; if (const_flag !== 1'b1) begin fails++; $display("FAIL entry13_flag: got %b want 1", const_flag); end
      tick();
      checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL hold_valid: got %b want 0", rd_valid); end
      checks++; if (constant !== 8'd255) begin fails++; $display("FAIL hold_const: got %0d want 255", constant); end
      checks++; if (const_flag !== 1'b1) begin fails++; $display("FAIL hold_flag: got %b want 1", const_flag); end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_idx = 4'd3; wr_data = 8'hA5;
      rd_req = 1'b1; rd_ptr = 5'b10011;
      tick();
      wr_en = 1'b0; rd_req = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL bypass_valid: got %b want 1", rd_valid); end
      checks++; if (constant !== 8'hA5) begin fails++; $display("FAIL bypass_const: got %0h want a5", constant); end
      rd_req = 1'b1; rd_ptr = 5'b10011;
      tick();
      rd_req = 1'b0;
      checks++; if (constant !== 8'hA5) begin fails++; $display("FAIL write_stored: got %0h want a5", constant); end
      rd_req = 1'b1; rd_ptr = 5'b10010;
      tick();
      rd_req = 1'b0;
      checks++; if (constant !== 8'd2) begin fails++; $display("FAIL write_neighbour: got %0d want 2", constant); end
   endtask

   task automatic test_back_to_back();
      rd_req = 1'b1; rd_ptr = 5'b10001;
      tick();
      checks++; if (rd_valid !== 1'b1 || constant !== 8'd1) begin fails++; $display("FAIL b2b_first: valid=%b const=%0d want 1/1", rd_valid, constant); end
      rd_ptr = 5'b11010;
      tick();
      checks++; if (rd_valid !== 1'b1 || constant !== 8'd15) begin fails++; $display("FAIL b2b_second: valid=%b const=%0d want 1/15", rd_valid, constant); end
      rd_ptr = 5'b00111;
      tick();
      rd_req = 1'b0;
      checks++; if (rd_valid !== 1'b1 || constant !== 8'd7 || const_flag !== 1'b0) begin fails++; $display("FAIL b2b_third: valid=%b const=%0d flag=%b want 1/7/0", rd_valid, constant, const_flag); end
      tick();
      checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", rd_valid); end
   endtask

   task automatic test_reload();
      int n;
      reload = 1'b1; rd_req = 1'b1; rd_ptr = 5'b10011;
      tick();
      reload = 1'b0; rd_req = 1'b0;
      checks++; if (rd_valid !== 1'b1 || constant !== 8'hA5) begin fails++; $display("FAIL reload_lookup: valid=%b const=%0h want 1/a5", rd_valid, constant); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reload_busy: got %b want 1", busy); end
      n = 1;
      wr_en = 1'b1; wr_idx = 4'd3; wr_data = 8'h11;
      tick();
      wr_en = 1'b0;
      checks++; if (wr_err !== 1'b1) begin fails++; $display("FAIL busy_wr_err: got %b want 1", wr_err); end
      if (busy) n++;
      tick();
      checks++; if (wr_err !== 1'b0) begin fails++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
      if (busy) n++;
      while (busy && n < 100) begin
         tick();
         if (busy) n++;
      end
      checks++; if (n !== 16) begin fails++; $display("FAIL reload_busy_len: got %0d want 16", n); end
      rd_req = 1'b1; rd_ptr = 5'b10011;
      tick();
      rd_req = 1'b0;
      checks++; if (constant !== 8'd128) begin fails++; $display("FAIL reload_restored: got %0d want 128", constant); end
      reload = 1'b1; wr_en = 1'b1; wr_idx = 4'd4; wr_data = 8'h77;
      tick();
      reload = 1'b0; wr_en = 1'b0;
      checks++; if (wr_err !== 1'b0) begin fails++; $display("FAIL reload_write_err: got %b want 0", wr_err); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reload_write_busy: got %b want 1", busy); end
      wait_ready();
      rd_req = 1'b1; rd_ptr = 5'b10100;
      tick();
      rd_req = 1'b0;
      checks++; if (constant !== 8'd8) begin fails++; $display("FAIL reload_write_dropped: got %0d want 8", constant); end
   endtask

   task automatic test_reset_mid_init();
      int n;
      int exp_tab[16] = '{127, 1, 2, 128, 8, 3, 4, 5, 32, 6, 15, 64, 7, 255, 19, 20};
      logic [7:0] e;
      Reset = 1'b1; rd_req = 1'b1; rd_ptr = 5'b10000;
      tick();
      Reset = 1'b0; rd_req = 1'b0;
      checks++; if (rd_valid !== 1'b0 || constant !== 8'd0) begin fails++; $display("FAIL reset_lookup_discard: valid=%b const=%0d want 0/0", rd_valid, constant); end
      checks++; if (dbg_state !== 1'b0) begin fails++; $display("FAIL reset_ready_state: got %b want 0", dbg_state); end
      wait_ready();
      reload = 1'b1;
      tick();
      reload = 1'b0;
      repeat (7) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      checks++; if (n !== 16) begin fails++; $display("FAIL midinit_busy_len: got %0d want 16", n); end
      for (int i = 0; i < 16; i++) begin
         e = 8'(exp_tab[i]);
         rd_req = 1'b1; rd_ptr = 5'(16 + i);
         tick();
         rd_req = 1'b0;
         checks++; if (constant !== e || const_flag !== 1'b1) begin fails++; $display("FAIL default_entry_%0d: const=%0d flag=%b want %0d/1", i, constant, const_flag, e); end
      end
   endtask

   task automatic test_wide();
      int n;
      w_reset = 1'b1;
      repeat (2) tick();
      w_reset = 1'b0;
      n = 0;
      while (w_busy && n < 200) begin
         n++;
         tick();
      end
      checks++; if (n !== 32) begin fails++; $display("FAIL wide_busy_len: got %0d want 32", n); end
      w_rd_req = 1'b1; w_rd_ptr = 6'b110100;
      tick();
      checks++; if (w_rd_valid !== 1'b1 || w_constant !== 16'd20 || w_const_flag !== 1'b1) begin fails++; $display("FAIL wide_entry20: valid=%b const=%0d flag=%b want 1/20/1", w_rd_valid, w_constant, w_const_flag); end
      w_rd_ptr = 6'b111111;
      tick();
      checks++; if (w_constant !== 16'd31 || w_const_flag !== 1'b1) begin fails++; $display("FAIL wide_entry31: const=%0d flag=%b want 31/1", w_constant, w_const_flag); end
      w_rd_ptr = 6'b101101;
      tick();
      checks++; if (w_constant !== 16'd255) begin fails++; $display("FAIL wide_entry13: const=%0d want 255", w_constant); end
      w_rd_ptr = 6'b011111;
      tick();
      w_rd_req = 1'b0;
      checks++; if (w_constant !== 16'd31 || w_const_flag !== 1'b0) begin fails++; $display("FAIL wide_reg_ptr: const=%0d flag=%b want 31/0", w_constant, w_const_flag); end
   endtask

   initial begin
      test_reset();
      test_init_busy();
      test_lookup();
      test_bypass();
      test_back_to_back();
      test_reload();
      test_reset_mid_init();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/operand_lut.md
OPERAND_LUT -- requirements
Module: operand_lut

Interface
REQ-001 SHALL provide parameter DW, default 8: constant/data width in bits, DW >= PW.
REQ-002 SHALL provide parameter PW, default 5: operand pointer width in bits; the MSB is the constant-select bit.
REQ-003 SHALL define local DEPTH = 2^(PW-1): number of table entries.
REQ-004 SHALL provide port Clk  input  1  rising-edge clock.
REQ-005 SHALL provide port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port reload  input  1  one-cycle pulse that restores the default table.
REQ-007 SHALL provide port rd_req  input  1  lookup request.
REQ-008 SHALL provide port rd_ptr  input  PW  operand pointer.
REQ-009 SHALL provide port wr_en  input  1  table write request.
REQ-010 SHALL provide port wr_idx  input  PW-1  table entry to write.
REQ-011 SHALL provide port wr_data  input  DW  value to write.
REQ-012 SHALL provide port busy  output  1  table initialising; lookups and writes refused.
REQ-013 SHALL provide port rd_valid  output  1  constant/const_flag valid this cycle.
REQ-014 SHALL provide port constant  output  DW  looked-up constant, or zero-extended register pointer.
REQ-015 SHALL provide port const_flag  output  1  1 = table constant, 0 = register pointer.
REQ-016 SHALL provide port wr_err  output  1  one-cycle pulse: write dropped while busy.

Function
REQ-017 SHALL define default entries 0..15 as 127,1,2,128,8,3,4,5,32,6,15,64,7,255,19,20, truncated to DW bits, and every entry i >= 16 as i mod 2^DW.
REQ-018 SHALL implement a two-state FSM: INIT -> READY when the entry DEPTH-1 default write completes; READY -> INIT on reload; INIT is not restarted by reload while already in INIT.
REQ-019 SHALL, in INIT, write default entry k on the k-th rising edge after entry to INIT (k = 0..DEPTH-1) using an internal counter; busy = 1 for exactly DEPTH cycles.
REQ-020 SHALL accept a lookup only when rd_req = 1 and busy = 0; rd_valid = 1 exactly one cycle after acceptance, otherwise 0.
REQ-021 SHALL, when rd_ptr[PW-1] = 1, return constant = table[rd_ptr[PW-2:0]] and const_flag = 1.
REQ-022 SHALL, when rd_ptr[PW-1] = 0, return constant = rd_ptr zero-extended to DW and const_flag = 0 without reading the table.
REQ-023 SHALL hold constant and const_flag at their last values when rd_valid = 0.
REQ-024 SHALL, in READY with wr_en = 1, write wr_data to table[wr_idx] at that clock edge.
REQ-025 SHALL, for a lookup accepted in the same cycle as a write to the same index, return wr_data (write-first bypass).
REQ-026 SHALL drop any write presented while busy = 1 and pulse wr_err for one cycle.
REQ-027 SHALL treat a reload in the same cycle as a write as: write dropped, wr_err = 0, INIT entered.
REQ-028 SHALL treat a reload in the same cycle as an accepted lookup as: the lookup completes with pre-reload table data.
REQ-029 SHALL have a single-cycle lookup latency; back-to-back lookups produce rd_valid on consecutive cycles.

Reset
REQ-030 SHALL, while Reset = 1, force state INIT, init counter = 0, rd_valid = 0, constant = 0, const_flag = 0, wr_err = 0, and busy = 1.
REQ-031 SHALL take Reset priority over reload, rd_req, and wr_en; Reset asserted mid-INIT or mid-lookup restarts INIT from entry 0 and discards the pending rd_valid.

Verification
REQ-032 SHALL verify: release Reset, hold rd_req = 1 -> busy high 16 cycles, no rd_valid; then ptr 5'b10000 -> constant 127, const_flag 1 next cycle.
REQ-033 SHALL verify: READY, ptr 5'b00110 -> constant 8'h06, const_flag 0; ptr 5'b11101 -> 255, const_flag 1.
REQ-034 SHALL verify: write idx 3 = 8'hA5 with same-cycle lookup 5'b10011 -> constant 8'hA5; a later lookup also -> 8'hA5.
REQ-035 SHALL verify: reload, then write during busy -> wr_err pulse; after 16 cycles, 5'b10011 -> 128.
REQ-036 SHALL verify: Reset asserted at INIT count 7 -> busy stays high a full 16 cycles after release; all defaults correct.
REQ-037 SHALL verify: PW = 6, DW = 16 -> DEPTH 32, busy 32 cycles; 6'b110100 -> 20, 6'b111111 -> 31.
